// File: rtl/logic_acc_pkg.sv
// Shared encodings for the logic accumulator: the 2-bit bitwise op code
// and the two-state handshake FSM.
package logic_acc_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_NOR = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_e;

endpackage

// File: rtl/logic_acc_unit_if.sv
// Beat input and result output handshake bundle of the logic accumulator.
// out_zero exists only when LOGIC_ACC_ZERO_EN is defined.
interface logic_acc_unit_if #(
  parameter int W     = 32,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_b;
  logic [1:0]       in_control;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [CNT_W-1:0] out_count;
`ifdef LOGIC_ACC_ZERO_EN
  logic             out_zero;
`endif

  modport master (
    output in_valid, in_b, in_control, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count
`ifdef LOGIC_ACC_ZERO_EN
    , input out_zero
`endif
  );

  modport slave (
    input  in_valid, in_b, in_control, in_first, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count
`ifdef LOGIC_ACC_ZERO_EN
    , output out_zero
`endif
  );

endinterface

// File: rtl/logic_acc_unit_logic_vec.sv
// Combinational W-bit bitwise operator using the logic unit op encoding.
module logic_vec
  import logic_acc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      default: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/logic_acc_unit.sv
// Folds a burst of operands into an accumulator and hands the result out over
// a valid/ready port. Define LOGIC_ACC_ZERO_EN to add the out_zero flag.
module logic_acc_unit
  import logic_acc_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  logic_acc_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_result_q, out_result_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_zero_q, out_zero_d;
  logic [W-1:0]     fold;

  logic_vec #(.W(W)) u_logic_vec (
    .a  (acc_q),
    .b  (bus.in_b),
    .op (bus.in_control),
    .y  (fold)
  );

  // Result registers only change on a closing beat, so they hold through backpressure.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_result_d = out_result_q;
    out_count_d  = out_count_q;
    out_zero_d   = out_zero_q;
    if (state_q == ST_ACC) begin
      if (bus.in_valid) begin
        if (bus.in_first) begin
          acc_d = bus.in_b;
          cnt_d = CNT_W'(1);
        end else begin
          acc_d = fold;
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (bus.in_last) begin
          out_result_d = acc_d;
          out_count_d  = cnt_d;
          out_zero_d   = (acc_d == '0);
          state_d      = ST_OUT;
        end
      end
    end else if (bus.out_ready) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ACC;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_result_q <= '0;
      out_count_q  <= '0;
      out_zero_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_result_q <= out_result_d;
      out_count_q  <= out_count_d;
      out_zero_q   <= out_zero_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_ACC);
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_result = out_result_q;
  assign bus.out_count  = out_count_q;

`ifdef LOGIC_ACC_ZERO_EN
  assign bus.out_zero = out_zero_q;
`else
  logic unused_zero;
  assign unused_zero = out_zero_q;
`endif

endmodule
